// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl download path: FSM encoding, default
// widths and the ioctl_index values agreed with the system-side loaders.
package ioctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FETCH,
        ST_WRITE,
        ST_GAP,
        ST_TAIL
    } state_t;

    localparam int ADDR_W_DEF = 25;
    localparam int CNT_W      = 8;

    localparam logic [7:0] IDX_ROM   = 8'd0;
    localparam logic [7:0] IDX_CART  = 8'd1;
    localparam logic [7:0] IDX_BIOS  = 8'd2;
    localparam logic [7:0] IDX_NVRAM = 8'd3;

    // Load value that makes the delay counter reach zero after n cycles in a
    // state (the state is left in the cycle the counter reads zero).
    function automatic logic [CNT_W-1:0] cyc_load(input int n);
        if (n <= 1) begin
            return '0;
        end
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/ioctl_delay_cnt.sv
// Loadable down-counter with a zero flag; times the SETUP, GAP and TAIL
// phases of the download streamer.
module ioctl_delay_cnt
    import ioctl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load takes priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ioctl_download_streamer.sv
// Initiator of the ioctl download bus: pulls bytes from a valid/ready source
// and writes them to the consumer with setup/gap/tail timing and ioctl_wait
// back-pressure.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for start; index/addr hold their last values
//   SETUP  | download high, no strobes yet; SETUP_CYC cycles
//   FETCH  | src_ready while wait is low; handshake captures the byte
//   WRITE  | one ioctl_wr cycle, held off while ioctl_wait is high
//   GAP    | at least WR_GAP idle cycles, stretched by ioctl_wait
//   TAIL   | download still high for TAIL_CYC cycles, then done pulse
module ioctl_download_streamer
    import ioctl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int SETUP_CYC = 4,
    parameter int WR_GAP    = 3,
    parameter int TAIL_CYC  = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        cfg_index,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic              src_valid,
    input  logic [7:0]        src_data,
    output logic              src_ready,
    output logic              ioctl_download,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_index,
    input  logic              ioctl_wait,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] SETUP_LOAD = cyc_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] GAP_LOAD   = cyc_load(WR_GAP);
    localparam logic [CNT_W-1:0] TAIL_LOAD  = cyc_load(TAIL_CYC);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [7:0]        dout_q, dout_d;
    logic [7:0]        index_q, index_d;
    logic              dl_q, dl_d;
    logic              done_q, done_d;
    logic              abort_pend_q, abort_pend_d;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_zero;
    logic              wr;
    logic              rdy;
    logic              to_tail;

    ioctl_delay_cnt #(.W(CNT_W)) u_delay (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Next-state and bus outputs. Every path into TAIL funnels through
    // to_tail so the tail timer is always loaded the same way.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        dout_d       = dout_q;
        index_d      = index_q;
        dl_d         = dl_q;
        done_d       = 1'b0;
        abort_pend_d = abort_pend_q;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        wr           = 1'b0;
        rdy          = 1'b0;
        to_tail      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (start) begin
                    index_d  = cfg_index;
                    addr_d   = cfg_base;
                    rem_d    = cfg_len;
                    dl_d     = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = SETUP_LOAD;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (abort || (cnt_zero && rem_q == '0)) begin
                    to_tail = 1'b1;
                end else if (cnt_zero) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Withholding ready during abort keeps a byte from being
                // consumed and then thrown away.
                rdy = !ioctl_wait && !abort;
                if (abort) begin
                    to_tail = 1'b1;
                end else if (rdy && src_valid) begin
                    dout_d  = src_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // An abort seen while the strobe is held off must survive
                // until the strobe has been issued.
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (!ioctl_wait) begin
                    wr    = 1'b1;
                    rem_d = rem_q - ADDR_W'(1);
                    if (abort || abort_pend_q) begin
                        to_tail = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (WR_GAP > 0) begin
                            cnt_load = 1'b1;
                            cnt_val  = GAP_LOAD;
                            state_d  = ST_GAP;
                        end else if (rem_q == ADDR_W'(1)) begin
                            to_tail = 1'b1;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    to_tail = 1'b1;
                end else if (cnt_zero && !ioctl_wait) begin
                    if (rem_q == '0) begin
                        to_tail = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_TAIL: begin
                if (cnt_zero) begin
                    dl_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (to_tail) begin
            cnt_load = 1'b1;
            cnt_val  = TAIL_LOAD;
            state_d  = ST_TAIL;
        end
    end

    // State and bus registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            dout_q       <= '0;
            index_q      <= '0;
            dl_q         <= 1'b0;
            done_q       <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            dout_q       <= dout_d;
            index_q      <= index_d;
            dl_q         <= dl_d;
            done_q       <= done_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    assign src_ready      = rdy;
    assign ioctl_wr       = wr;
    assign ioctl_download = dl_q;
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = dout_q;
    assign ioctl_index    = index_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;

endmodule

// File: tb/tb_ioctl_download_streamer.sv
// Scoreboard bench for ioctl_download_streamer: expected (addr, byte) pairs
// are queued when source bytes are loaded and popped on each ioctl_wr.
module tb_ioctl_download_streamer;
    import ioctl_pkg::*;

    localparam int ADDR_W    = 25;
    localparam int SETUP_CYC = 4;
    localparam int WR_GAP    = 3;
    localparam int TAIL_CYC  = 4;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic [7:0]        cfg_index;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_len;
    logic              src_valid;
    logic [7:0]        src_data;
    logic              src_ready;
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [7:0]        ioctl_index;
    logic              ioctl_wait;
    logic              busy;
    logic              done;

    ioctl_download_streamer #(
        .ADDR_W    (ADDR_W),
        .SETUP_CYC (SETUP_CYC),
        .WR_GAP    (WR_GAP),
        .TAIL_CYC  (TAIL_CYC)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .cfg_index      (cfg_index),
        .cfg_base       (cfg_base),
        .cfg_len        (cfg_len),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[$];
    logic [7:0] ref_b[$];
    exp_t       e;

    int   checks = 0;
    int   errors = 0;
    int   ncyc = 0;
    int   wr_cnt = 0, hs_cnt = 0, done_cnt = 0, dl_cnt = 0, rdy_cnt = 0;
    int   start_k = 0, first_wr_k = 0, last_wr_k = -1, done_k = 0, abort_k = 0;
    int   vmode = 0;
    bit   exact_gap = 1'b0;
    bit   hs_flag = 1'b0;
    logic [7:0] cur_idx = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_stats();
        wr_cnt   = 0;
        hs_cnt   = 0;
        done_cnt = 0;
        dl_cnt   = 0;
        rdy_cnt  = 0;
        done_k   = 0;
        abort_k  = 0;
    endtask

    task automatic load_bytes(input logic [ADDR_W-1:0] base, input int n_src, input int n_exp);
        logic [7:0] b;
        exp_q.delete();
        src_q.delete();
        ref_b.delete();
        for (int i = 0; i < n_src; i++) begin
            b = 8'($urandom_range(0, 255));
            src_q.push_back(b);
            ref_b.push_back(b);
            if (i < n_exp) begin
                exp_q.push_back(exp_t'{a: base + ADDR_W'(i), d: b});
            end
        end
    endtask

    task automatic run_xfer(input logic [7:0] idx, input logic [ADDR_W-1:0] base,
                            input logic [ADDR_W-1:0] len);
        clear_stats();
        cur_idx   = idx;
        cfg_index = idx;
        cfg_base  = base;
        cfg_len   = len;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim && done_cnt == 0; i++) begin
            @(negedge clk_sys);
            #1;
        end
        tick();
        tick();
    endtask

    // Source model: presents the head of src_q according to vmode and drops
    // it after a handshake seen on the preceding low phase.
    initial begin
        bit v;
        src_valid = 1'b0;
        src_data  = 8'h00;
        forever begin
            @(posedge clk_sys);
            #1;
            if (hs_flag && src_q.size() > 0) begin
                void'(src_q.pop_front());
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (ncyc % 3 == 0);
                default: v = 1'b0;
            endcase
            src_valid = v && (src_q.size() > 0);
            src_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
    end

    // Bus monitor: scoreboard compare on every strobe plus protocol checks.
    initial begin
        forever begin
            @(negedge clk_sys);
            ncyc++;
            if (start && !busy) begin
                start_k   = ncyc;
                last_wr_k = -1;
            end
            if (abort) abort_k = ncyc;
            if (ioctl_download) dl_cnt++;
            if (done) begin
                done_cnt++;
                done_k = ncyc;
            end
            if (src_ready) begin
                rdy_cnt++;
                chk("ready_while_wait", 32'(ioctl_wait), 32'd0);
            end
            hs_flag = src_valid && src_ready;
            if (hs_flag) hs_cnt++;
            if (ioctl_wr) begin
                wr_cnt++;
                chk("wr_while_wait", 32'(ioctl_wait), 32'd0);
                chk("wr_index", 32'(ioctl_index), 32'(cur_idx));
                chk("wr_download", 32'(ioctl_download), 32'd1);
                if (last_wr_k < 0) begin
                    first_wr_k = ncyc;
                end else if (exact_gap) begin
                    chk("wr_interval", ncyc - last_wr_k, WR_GAP + 2);
                end else begin
                    chk("wr_spacing_min", 32'(ncyc - last_wr_k >= WR_GAP + 2), 32'd1);
                end
                last_wr_k = ncyc;
                chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(ioctl_addr), 32'(e.a));
                    chk("wr_data", 32'(ioctl_dout), 32'(e.d));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        cfg_index  = 8'h00;
        cfg_base   = '0;
        cfg_len    = '0;
        ioctl_wait = 1'b0;

        #2;
        chk("rst_download", 32'(ioctl_download), 32'd0);
        chk("rst_wr", 32'(ioctl_wr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(src_ready), 32'd0);
        chk("rst_addr", 32'(ioctl_addr), 32'd0);
        repeat (2) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        tick();

        // Basic 4-byte transfer, source always valid, no back-pressure.
        vmode = 0;
        exact_gap = 1'b1;
        load_bytes(25'h100, 4, 4);
        run_xfer(8'h05, 25'h100, 25'd4);
        wait_done(200);
        exact_gap = 1'b0;
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_wr_cnt", wr_cnt, 4);
        chk("t1_first_wr_latency", first_wr_k - start_k, SETUP_CYC + 2);
        chk("t1_sb_empty", exp_q.size(), 0);
        chk("t1_index_hold", 32'(ioctl_index), 32'h05);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_download_after", 32'(ioctl_download), 32'd0);

        // Zero-length transfer.
        load_bytes(25'h0, 0, 0);
        run_xfer(IDX_NVRAM, 25'h55, 25'd0);
        wait_done(200);
        chk("t2_download_cycles", dl_cnt, SETUP_CYC + TAIL_CYC);
        chk("t2_wr_cnt", wr_cnt, 0);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_ready_cnt", rdy_cnt, 0);
        chk("t2_index", 32'(ioctl_index), 32'(IDX_NVRAM));

        // Back-pressure held across the second WRITE.
        load_bytes(25'h200, 3, 3);
        run_xfer(8'h01, 25'h200, 25'd3);
        for (int i = 0; i < 200 && hs_cnt < 2; i++) begin
            @(negedge clk_sys);
            #1;
        end
        chk("t3_second_fetch_seen", 32'(hs_cnt >= 2), 32'd1);
        tick();
        ioctl_wait = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            chk("t3_wr_held", 32'(ioctl_wr), 32'd0);
            chk("t3_addr_stable", 32'(ioctl_addr), 32'h201);
            chk("t3_dout_stable", 32'(ioctl_dout), 32'(ref_b[1]));
        end
        tick();
        ioctl_wait = 1'b0;
        @(negedge clk_sys);
        chk("t3_wr_on_release", 32'(ioctl_wr), 32'd1);
        wait_done(200);
        chk("t3_wr_cnt", wr_cnt, 3);
        chk("t3_sb_empty", exp_q.size(), 0);
        chk("t3_done_cnt", done_cnt, 1);

        // Source valid one cycle in three.
        vmode = 1;
        load_bytes(25'h300, 6, 6);
        run_xfer(8'h02, 25'h300, 25'd6);
        wait_done(400);
        chk("t4_wr_cnt", wr_cnt, 6);
        chk("t4_hs_cnt", hs_cnt, 6);
        chk("t4_sb_empty", exp_q.size(), 0);
        chk("t4_src_drained", src_q.size(), 0);
        vmode = 0;

        // Address wrap at the top of the space.
        load_bytes(25'h1FFFFFF, 2, 2);
        run_xfer(8'h00, 25'h1FFFFFF, 25'd2);
        wait_done(200);
        chk("t5_wr_cnt", wr_cnt, 2);
        chk("t5_sb_empty", exp_q.size(), 0);

        // Abort during GAP after the second of eight bytes.
        load_bytes(25'h400, 8, 2);
        run_xfer(8'h04, 25'h400, 25'd8);
        for (int i = 0; i < 200 && wr_cnt < 2; i++) begin
            @(negedge clk_sys);
            #1;
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(200);
        chk("t6_wr_cnt", wr_cnt, 2);
        chk("t6_hs_cnt", hs_cnt, 2);
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_abort_to_done", done_k - abort_k, TAIL_CYC + 1);
        src_q.delete();

        // Abort while stalled in FETCH with no source data.
        vmode = 2;
        load_bytes(25'h500, 3, 0);
        run_xfer(8'h06, 25'h500, 25'd3);
        for (int i = 0; i < 200 && !src_ready; i++) begin
            @(negedge clk_sys);
            #1;
        end
        chk("t7_fetch_reached", 32'(src_ready), 32'd1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(200);
        chk("t7_wr_cnt", wr_cnt, 0);
        chk("t7_done_cnt", done_cnt, 1);
        chk("t7_abort_to_done", done_k - abort_k, TAIL_CYC + 1);
        src_q.delete();
        vmode = 0;

        // Asynchronous reset in the middle of a transfer.
        load_bytes(25'h600, 4, 4);
        run_xfer(8'h07, 25'h600, 25'd4);
        for (int i = 0; i < 200 && wr_cnt < 1; i++) begin
            @(negedge clk_sys);
            #1;
        end
        #1 reset_n = 1'b0;
        #1;
        chk("t8_download", 32'(ioctl_download), 32'd0);
        chk("t8_busy", 32'(busy), 32'd0);
        chk("t8_wr", 32'(ioctl_wr), 32'd0);
        chk("t8_ready", 32'(src_ready), 32'd0);
        chk("t8_addr", 32'(ioctl_addr), 32'd0);
        chk("t8_index", 32'(ioctl_index), 32'd0);
        chk("t8_dout", 32'(ioctl_dout), 32'd0);
        chk("t8_done", 32'(done), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        src_q.delete();
        repeat (3) tick();
        chk("t8_idle_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
